mbist_err_detect: RTL
=====================

// Module: mbist_err_detect
// PURPOSE
//  Stage directly upstream of the MBIST address-repair block. Read-data comparator.
//  - Delays each issued read's address and expected data by the SRAM read latency.
//  - Compares them with the returned memory data.
//  - On a new failing address, emits a one-cycle Error pulse with ErrorAddr.
//  - Filters out repeat failures of the same address, so no second repair entry is allocated.
//  - Flags an unrepairable memory once more distinct addresses fail than the repair limit.
// PARAMETERS
//  BIST_ADDR_WD    9    memory address width
//  BIST_DATA_WD    32   memory data width
//  BIST_RD_LAT     1    SRAM read latency in clk cycles, legal range 1..4
//  BIST_ERR_LIMIT  4    distinct failing addresses the repair block can absorb, 1..15
// PORTS
//  clk            in   1       BIST clock
//  rst_n          in   1       asynchronous active-low reset
//  bist_clear     in   1       sync clear of pipeline, logged addresses, counters, fail flag
//  bist_rd        in   1       read issued to SRAM this cycle
//  bist_cmp_en    in   1       compare this read (0 = read without check)
//  bist_addr      in   ADDR_WD address of issued read
//  bist_exp_data  in   DATA_WD expected data of issued read
//  mem_rdata      in   DATA_WD SRAM read data, valid BIST_RD_LAT cycles after bist_rd
//  Error          out  1       one-cycle pulse: new distinct failing address (to repair block)
//  ErrorAddr      out  ADDR_WD failing address, valid while Error=1, held otherwise
//  bist_err_cnt   out  4       distinct failing addresses logged, saturates at BIST_ERR_LIMIT
//  bist_fail      out  1       sticky: more distinct failures than BIST_ERR_LIMIT
//  bist_cmp_busy  out  1       any read in flight in the delay pipe
// BEHAVIOUR
//  Reset values (rst_n low, asynchronous)
//  - Error=0, ErrorAddr=0, bist_err_cnt=0, bist_fail=0, bist_cmp_busy=0.
//  - All pipe valids and logged-address entries are cleared.
//  Delay pipe
//  - BIST_RD_LAT-deep shift register of {valid=bist_rd&bist_cmp_en, addr, exp_data}.
//  - Advances every cycle; no stall.
//  - The stage-LAT entry aligns with mem_rdata.
//  Compare
//  - Stage-LAT valid and mem_rdata != exp_data gives a raw miscompare (combinational).
//  - All outputs are registered. A read issued at cycle T raises Error at T+BIST_RD_LAT+1.
//  Duplicate filter
//  - Raw miscompare addr is matched against logged entries [0..bist_err_cnt-1].
//  - On a hit: no Error pulse, no counter change.
//  New distinct failure
//  - If bist_err_cnt < LIMIT: log addr at index bist_err_cnt, increment count, pulse Error, load ErrorAddr.
//  - If bist_err_cnt == LIMIT: no Error pulse, set bist_fail (sticky until clear or reset).
//  - Back-to-back miscompares on consecutive cycles each produce a pulse if distinct.
//  - Same address on consecutive cycles: second is filtered, because the log is written in the first cycle's edge.
//  bist_clear
//  - Synchronous. Zeroes pipe valids, log, count, bist_fail and Error next cycle.
//  - Has priority over a simultaneous compare; in-flight reads are discarded.
//  - ErrorAddr is not cleared.
//  bist_cmp_busy = OR of pipe valids.
//  Other rules
//  - mem_rdata is ignored when the aligned stage is invalid; X on it must not propagate.
//  - rst_n asserted mid-test: immediate return to reset values; no partial pulse.
// CONFIGURATION
//  MBIST_ERR_SYND_EN defined
//  - Adds output ErrorSyn [BIST_DATA_WD] = mem_rdata ^ exp_data of the reported failure.
//  - Registered with Error, reset 0, held between pulses.
//  - Used for bit-fail diagnosis.
//  MBIST_ERR_SYND_EN undefined
//  - Port and its registers are absent; all other behaviour is identical.
// TESTING
//  1. LAT=1, reads 0x000..0x00F all matching -> Error never 1, cnt=0, fail=0; busy drops 2 cycles after last read.
//  2. LAT=2, read addr 0x005 at T with rdata^exp=0x0000_0100 -> Error=1 only at T+3, ErrorAddr=0x005, cnt=1, ErrorSyn=0x100 (macro on).
//  3. Addr 0x005 fails in 3 separate march passes -> exactly one Error pulse, cnt stays 1.
//  4. LIMIT=4, distinct failures at 0x010,0x011,0x012,0x013,0x014 -> 4 pulses, cnt=4; 0x014 gives no pulse and fail=1 one cycle after its compare.
//  5. Failing reads on consecutive cycles to 0x020 then 0x021 -> two adjacent Error pulses, addresses in order; 0x020 twice back-to-back -> one pulse.
//  6. bist_clear asserted in the same cycle as a failing compare, with reads in flight -> no Error, cnt=0, fail=0, busy=0 next cycle. Repeat with rst_n mid-run -> same result asynchronously.

Source files
------------

// File: rtl/mbist_err_detect.sv
// MBIST read-data comparator: delays each read's address/expected data by the SRAM
// latency, reports new distinct failing addresses once, and flags overflow of the repair
// capacity. Define MBIST_ERR_SYND_EN to add the ErrorSyn bit-fail syndrome output.
module mbist_err_detect #(
  parameter int BIST_ADDR_WD   = 9,
  parameter int BIST_DATA_WD   = 32,
  parameter int BIST_RD_LAT    = 1,
  parameter int BIST_ERR_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bist_clear,
  input  logic                    bist_rd,
  input  logic                    bist_cmp_en,
  input  logic [BIST_ADDR_WD-1:0] bist_addr,
  input  logic [BIST_DATA_WD-1:0] bist_exp_data,
  input  logic [BIST_DATA_WD-1:0] mem_rdata,
  output logic                    Error,
  output logic [BIST_ADDR_WD-1:0] ErrorAddr,
  output logic [3:0]              bist_err_cnt,
  output logic                    bist_fail,
`ifdef MBIST_ERR_SYND_EN
  output logic [BIST_DATA_WD-1:0] ErrorSyn,
`endif
  output logic                    bist_cmp_busy
);

  localparam int LAST = BIST_RD_LAT - 1;

  logic                    pipe_vld  [BIST_RD_LAT];
  logic [BIST_ADDR_WD-1:0] pipe_addr [BIST_RD_LAT];
  logic [BIST_DATA_WD-1:0] pipe_exp  [BIST_RD_LAT];
  logic [BIST_ADDR_WD-1:0] err_log   [BIST_ERR_LIMIT];

  logic raw_miscmp;
  logic log_hit;
  logic new_fail;
  logic log_room;

  // Valid bits are the only pipe state that must be reset; clear drops all in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BIST_RD_LAT; i++) pipe_vld[i] <= 1'b0;
    end else if (bist_clear) begin
      for (int i = 0; i < BIST_RD_LAT; i++) pipe_vld[i] <= 1'b0;
    end else begin
      pipe_vld[0] <= bist_rd & bist_cmp_en;
      for (int i = 1; i < BIST_RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_addr[0] <= bist_addr;
    pipe_exp[0]  <= bist_exp_data;
    for (int i = 1; i < BIST_RD_LAT; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_exp[i]  <= pipe_exp[i-1];
    end
  end

  always_comb begin
    bist_cmp_busy = 1'b0;
    for (int i = 0; i < BIST_RD_LAT; i++) bist_cmp_busy = bist_cmp_busy | pipe_vld[i];
  end

  // The valid term gates mem_rdata so unknown data on idle cycles cannot reach the outputs.
  always_comb begin
    raw_miscmp = pipe_vld[LAST] && (mem_rdata != pipe_exp[LAST]);
    log_hit    = 1'b0;
    for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
      if ((4'(i) < bist_err_cnt) && (err_log[i] == pipe_addr[LAST])) log_hit = 1'b1;
    end
    new_fail = raw_miscmp & ~log_hit;
    log_room = bist_err_cnt < 4'(BIST_ERR_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Error        <= 1'b0;
      ErrorAddr    <= '0;
      bist_err_cnt <= '0;
      bist_fail    <= 1'b0;
      for (int i = 0; i < BIST_ERR_LIMIT; i++) err_log[i] <= '0;
    end else if (bist_clear) begin
      Error        <= 1'b0;
      bist_err_cnt <= '0;
      bist_fail    <= 1'b0;
      for (int i = 0; i < BIST_ERR_LIMIT; i++) err_log[i] <= '0;
    end else begin
      Error <= new_fail & log_room;
      if (new_fail && log_room) begin
        ErrorAddr    <= pipe_addr[LAST];
        bist_err_cnt <= bist_err_cnt + 4'd1;
        for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
          if (4'(i) == bist_err_cnt) err_log[i] <= pipe_addr[LAST];
        end
      end
      if (new_fail && !log_room) bist_fail <= 1'b1;
    end
  end

`ifdef MBIST_ERR_SYND_EN
  // Syndrome survives a clear, like ErrorAddr, so diagnosis can still read the last failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ErrorSyn <= '0;
    end else if (!bist_clear && new_fail && log_room) begin
      ErrorSyn <= mem_rdata ^ pipe_exp[LAST];
    end
  end
`endif

endmodule
